st2bus_pack: RTL and testbench
==============================

// Module: st2bus_pack
// PURPOSE
//  Downstream of the turbo decoder array output mux. Consumes the 8-bit Avalon-ST decoded-bit
//  stream (one 1024-bit turbo block = 128 bytes per sop..eop packet) and packs it LSB-first into
//  BUS_W-wide words for the host write path. Buffers words in a small FIFO with valid/ready out.
//  Enforces packet framing: malformed packets are flagged, never silently merged with neighbours.
// PARAMETERS
//  ST            8    stream data width (bits); fixed at 8
//  BUS_W         512  output word width; BUS_W/ST = LANES = 64 bytes per word
//  BYTES_PER_PKT 128  bytes per turbo packet; must be a multiple of LANES
//  FIFO_DEPTH    4    output word FIFO depth; power of 2, >= 2
// PORTS
//  clk        in   1        stream/bus clock (clk_st domain)
//  rst_n      in   1        asynchronous reset, active low
//  st_data    in   ST       decoded byte
//  st_valid   in   1        byte valid
//  st_sop     in   1        first byte of packet
//  st_eop     in   1        last byte of packet
//  st_ready   out  1        block accepts a byte this cycle
//  bus_data   out  BUS_W    packed word; byte k at [8k+7:8k]
//  bus_sop    out  1        word is first word of packet
//  bus_eop    out  1        word is last word of packet
//  bus_valid  out  1        word available
//  bus_ready  in   1        consumer takes word when bus_valid&bus_ready
//  pkt_err    out  1        one-cycle pulse per framing error
// BEHAVIOUR
//  - Reset: all outputs 0 (st_ready, bus_valid, bus_sop, bus_eop, pkt_err, bus_data); FIFO
//    emptied, lane/byte counters 0, FSM=IDLE. Reset mid-packet discards partial word and FIFO.
//  - Accept = st_valid & st_ready. st_ready is registered: 1 iff FIFO holds < FIFO_DEPTH words
//    after this cycle's push/pop; no combinational path from bus_ready to st_ready.
//  - FSM IDLE: accept with sop -> store byte lane 0, go PACK. Accept without sop -> drop byte,
//    pkt_err pulse (once per run of orphan bytes), stay IDLE.
//  - FSM PACK: store byte at lane = byte_cnt mod LANES. Push word to FIFO when lane LANES-1 is
//    filled or on eop. bus_sop=1 on first word of packet; bus_eop=1 on word containing eop.
//    * eop at byte_cnt==BYTES_PER_PKT-1: normal, -> IDLE.
//    * eop early: unfilled lanes zero, push with bus_eop=1, pkt_err pulse, -> IDLE.
//    * sop while in PACK: partial word discarded (words already pushed stay), pkt_err pulse,
//      new packet starts at lane 0 with this byte.
//    * byte BYTES_PER_PKT-1 without eop: push with bus_eop=1, pkt_err, -> DISCARD.
//  - FSM DISCARD: drop bytes until an accepted eop (-> IDLE); accepted sop -> PACK as new packet.
//  - Latency: word completed by beat accepted in cycle N is on bus_data with bus_valid=1 in N+1
//    when FIFO was empty. FIFO is show-ahead; order strictly preserved.
//  - Simultaneous push and pop: allowed at any occupancy < FIFO_DEPTH; count unchanged.
//  - Counters: byte_cnt wraps to 0 at packet end; widths ceil(log2) of their ranges.
// CONFIGURATION
//  ST2BUS_STATS_EN defined: adds ports pkt_cnt out 16 (complete well-formed packets pushed)
//    and err_cnt out 16 (pkt_err pulses); both reset to 0, saturate at 16'hFFFF.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  T1 two back-to-back packets, bytes 0x00..0x7F each, bus_ready=1 -> 4 words; word0
//     [7:0]=0x00,[511:504]=0x3F; sop on words 0,2, eop on 1,3; pkt_err never.
//  T2 bus_ready=0, 3 packets offered -> st_ready=0 cycle after 256th byte; release bus_ready
//     -> all 6 words out in order, no byte lost or duplicated.
//  T3 eop on byte 100 -> word1 bytes 64..99 then zeros, bus_eop=1, pkt_err one pulse.
//  T4 sop at byte 30 of packet -> no word from partial packet, pkt_err pulse, next packet intact.
//  T5 rst_n low at byte 70 (async, mid-cycle) -> bus_valid=0 immediately; after release clean
//     packet yields 2 correct words.
//  T6 with ST2BUS_STATS_EN: after T1 pkt_cnt=2, err_cnt=0; after T3 err_cnt=1, pkt_cnt=2.

Source files
------------

// File: rtl/st2bus_pack.sv
// Packs an 8-bit sop/eop framed byte stream LSB-first into BUS_W words behind a show-ahead FIFO.
// Optional ST2BUS_STATS_EN adds saturating pkt_cnt / err_cnt outputs.
module st2bus_pack #(
    parameter int ST            = 8,
    parameter int BUS_W         = 512,
    parameter int BYTES_PER_PKT = 128,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ST-1:0]    st_data,
    input  logic             st_valid,
    input  logic             st_sop,
    input  logic             st_eop,
    output logic             st_ready,
    output logic [BUS_W-1:0] bus_data,
    output logic             bus_sop,
    output logic             bus_eop,
    output logic             bus_valid,
    input  logic             bus_ready,
`ifdef ST2BUS_STATS_EN
    output logic [15:0]      pkt_cnt,
    output logic [15:0]      err_cnt,
`endif
    output logic             pkt_err
);

    localparam int LANES  = BUS_W / ST;
    localparam int LANE_W = $clog2(LANES);
    localparam int CNT_W  = $clog2(BYTES_PER_PKT);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int OCC_W  = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, PACK, DISCARD} state_t;

    state_t             state_p0, state_nxt;
    logic [CNT_W-1:0]   byte_cnt_p0, byte_cnt_nxt, cnt_eff;
    logic [LANE_W-1:0]  lane;
    logic [BUS_W-1:0]   word_p0, word_nxt;
    logic               orphan_p0, orphan_nxt;
    logic               accept, start, pack_beat, last_byte;
    logic               push, push_sop, pop, err_nxt;

    logic [BUS_W-1:0]      fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_sop, fifo_eop;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [OCC_W-1:0]      occ, occ_nxt;

    // Stage 0: beat classification and lane placement
    assign accept    = st_valid & st_ready;
    assign start     = accept & st_sop;
    assign pack_beat = start | (accept & (state_p0 == PACK));
    assign cnt_eff   = start ? '0 : byte_cnt_p0;
    assign lane      = cnt_eff[LANE_W-1:0];
    assign last_byte = (cnt_eff == CNT_W'(BYTES_PER_PKT - 1));
    assign push      = pack_beat & (st_eop | (lane == LANE_W'(LANES - 1)));
    assign push_sop  = ((cnt_eff >> LANE_W) == '0);

    // A new packet always starts from a zero word, so stale partial data never leaks
    always_comb begin
        word_nxt = start ? '0 : word_p0;
        word_nxt[int'(lane) * ST +: ST] = st_data;
    end

    always_comb begin
        state_nxt    = state_p0;
        byte_cnt_nxt = byte_cnt_p0;
        orphan_nxt   = orphan_p0;
        err_nxt      = 1'b0;
        if (pack_beat) begin
            orphan_nxt = 1'b0;
            err_nxt    = (st_sop & (state_p0 == PACK)) | (st_eop ^ last_byte);
            if (st_eop) begin
                state_nxt    = IDLE;
                byte_cnt_nxt = '0;
            end else if (last_byte) begin
                state_nxt    = DISCARD;
                byte_cnt_nxt = '0;
            end else begin
                state_nxt    = PACK;
                byte_cnt_nxt = cnt_eff + CNT_W'(1);
            end
        end else if (accept) begin
            case (state_p0)
                IDLE: begin
                    err_nxt    = ~orphan_p0;
                    orphan_nxt = ~st_eop;
                end
                DISCARD: begin
                    if (st_eop) state_nxt = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0    <= IDLE;
            byte_cnt_p0 <= '0;
            orphan_p0   <= 1'b0;
            pkt_err     <= 1'b0;
        end else begin
            state_p0    <= state_nxt;
            byte_cnt_p0 <= byte_cnt_nxt;
            orphan_p0   <= orphan_nxt;
            pkt_err     <= err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (pack_beat) word_p0 <= push ? '0 : word_nxt;
    end

    // Stage 1: show-ahead word FIFO
    assign pop       = bus_valid & bus_ready;
    assign occ_nxt   = occ + OCC_W'(push) - OCC_W'(pop);
    assign bus_valid = (occ != '0);
    assign bus_data  = bus_valid ? fifo_data[rd_ptr] : '0;
    assign bus_sop   = bus_valid & fifo_sop[rd_ptr];
    assign bus_eop   = bus_valid & fifo_eop[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= word_nxt;
            fifo_sop[wr_ptr]  <= push_sop;
            fifo_eop[wr_ptr]  <= st_eop | last_byte;
        end
    end

    // st_ready is a register so bus_ready never reaches it combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            st_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            occ      <= occ_nxt;
            st_ready <= (occ_nxt < OCC_W'(FIFO_DEPTH));
        end
    end

`ifdef ST2BUS_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (push & st_eop & last_byte) pkt_cnt <= sat_inc(pkt_cnt);
            if (err_nxt)                   err_cnt <= sat_inc(err_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_st2bus_pack.sv
// Directed bench for st2bus_pack: packet table plus backpressure and async-reset sequences.
// Define ST2BUS_STATS_EN to also exercise the statistics counters.
module tb_st2bus_pack;

    localparam int BUS_W = 512;
    localparam int LANES = 64;
    localparam int MAXW  = 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       st_data;
    logic             st_valid, st_sop, st_eop, st_ready;
    logic [BUS_W-1:0] bus_data;
    logic             bus_sop, bus_eop, bus_valid, bus_ready, pkt_err;
`ifdef ST2BUS_STATS_EN
    logic [15:0]      pkt_cnt, err_cnt;
`endif

    st2bus_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_data   (st_data),
        .st_valid  (st_valid),
        .st_sop    (st_sop),
        .st_eop    (st_eop),
        .st_ready  (st_ready),
        .bus_data  (bus_data),
        .bus_sop   (bus_sop),
        .bus_eop   (bus_eop),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
`ifdef ST2BUS_STATS_EN
        .pkt_cnt   (pkt_cnt),
        .err_cnt   (err_cnt),
`endif
        .pkt_err   (pkt_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [BUS_W-1:0] got_data [MAXW];
    logic             got_sop  [MAXW];
    logic             got_eop  [MAXW];
    int               got_n     = 0;
    int               err_total = 0;

    always @(negedge clk) begin
        if (pkt_err) err_total++;
        if (bus_valid && bus_ready) begin
            if (got_n < MAXW) begin
                got_data[got_n] = bus_data;
                got_sop[got_n]  = bus_sop;
                got_eop[got_n]  = bus_eop;
            end
            got_n++;
        end
    end

    task automatic chk_w(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [BUS_W-1:0] exp_word(input logic [7:0] base, input int off, input int fill);
        logic [BUS_W-1:0] w;
        w = '0;
        for (int l = 0; l < LANES; l++)
            if (l < fill) w[l*8 +: 8] = base + 8'(off + l);
        return w;
    endfunction

    // Bytes carry base+i; sop on beat 0 (if sop0) and on beat sop_mid; eop on the final beat.
    task automatic send_pkt(input int len, input bit sop0, input bit eop_end, input int sop_mid,
                            input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            int  t;
            bit  done;
            st_data  = base + 8'(i);
            st_sop   = (sop0 && i == 0) || (i == sop_mid);
            st_eop   = eop_end && (i == len - 1);
            st_valid = 1'b1;
            t = 0;
            done = 1'b0;
            while (!done) begin
                @(negedge clk);
                if (st_ready) done = 1'b1;
                @(posedge clk);
                #1;
                t++;
                if (!done && t > 1000) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: actual=stalled beat %0d required=accepted", i);
                    st_valid = 1'b0;
                    st_sop   = 1'b0;
                    st_eop   = 1'b0;
                    return;
                end
            end
        end
        st_valid = 1'b0;
        st_sop   = 1'b0;
        st_eop   = 1'b0;
    endtask

    task automatic check_words(input string tag, input int wb, input int nw, input logic [7:0] base,
                               input int skip, input int good);
        for (int w = 0; w < nw; w++) begin
            int idx;
            int fill;
            idx = wb + w;
            if (idx >= got_n || idx >= MAXW) break;
            fill = good - 64 * w;
            if (fill > 64) fill = 64;
            chk_w($sformatf("%s_w%0d_data", tag, w), got_data[idx], exp_word(base, skip + 64 * w, fill));
            chk_i($sformatf("%s_w%0d_sop", tag, w), int'(got_sop[idx]), (w == 0) ? 1 : 0);
            chk_i($sformatf("%s_w%0d_eop", tag, w), int'(got_eop[idx]), (w == nw - 1) ? 1 : 0);
        end
    endtask

    typedef struct {
        int         len;
        bit         sop0;
        bit         eop_end;
        int         sop_mid;
        int         skip;
        logic [7:0] base;
        int         exp_words;
        int         exp_err;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int wb, eb, good;
        logic [7:0] t2_base [3];

        vecs[0] = '{128, 1'b1, 1'b1, -1,  0, 8'h00, 2, 0};  // T1 packet A
        vecs[1] = '{128, 1'b1, 1'b1, -1,  0, 8'h00, 2, 0};  // T1 packet B
        vecs[2] = '{100, 1'b1, 1'b1, -1,  0, 8'h00, 2, 1};  // early eop, 100th byte
        vecs[3] = '{158, 1'b1, 1'b1, 30, 30, 8'h10, 2, 1};  // sop restart at byte 30
        vecs[4] = '{130, 1'b1, 1'b1, -1,  0, 8'h80, 2, 1};  // oversize, tail discarded
        vecs[5] = '{5,   1'b0, 1'b1, -1,  0, 8'hC0, 0, 1};  // orphan bytes in IDLE
        vecs[6] = '{1,   1'b1, 1'b1, -1,  0, 8'hE7, 1, 1};  // single-byte packet
        vecs[7] = '{128, 1'b1, 1'b1, -1,  0, 8'h40, 2, 0};  // clean packet afterwards

        rst_n     = 1'b0;
        st_data   = '0;
        st_valid  = 1'b0;
        st_sop    = 1'b0;
        st_eop    = 1'b0;
        bus_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_i("rst_st_ready", int'(st_ready), 0);
        chk_i("rst_bus_valid", int'(bus_valid), 0);
        chk_i("rst_bus_sop", int'(bus_sop), 0);
        chk_i("rst_bus_eop", int'(bus_eop), 0);
        chk_i("rst_pkt_err", int'(pkt_err), 0);
        chk_w("rst_bus_data", bus_data, '0);
`ifdef ST2BUS_STATS_EN
        chk_i("rst_pkt_cnt", int'(pkt_cnt), 0);
        chk_i("rst_err_cnt", int'(err_cnt), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_i("post_rst_st_ready", int'(st_ready), 1);

        bus_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            wb = got_n;
            eb = err_total;
            send_pkt(vecs[v].len, vecs[v].sop0, vecs[v].eop_end, vecs[v].sop_mid, vecs[v].base);
            repeat (10) @(posedge clk);
            #1;
            good = vecs[v].len - vecs[v].skip;
            if (good > 128) good = 128;
            chk_i($sformatf("v%0d_words", v), got_n - wb, vecs[v].exp_words);
            check_words($sformatf("v%0d", v), wb, vecs[v].exp_words, vecs[v].base, vecs[v].skip, good);
            chk_i($sformatf("v%0d_pkt_err", v), err_total - eb, vecs[v].exp_err);
`ifdef ST2BUS_STATS_EN
            if (v == 1) begin
                chk_i("t6_pkt_cnt_after_t1", int'(pkt_cnt), 2);
                chk_i("t6_err_cnt_after_t1", int'(err_cnt), 0);
            end
            if (v == 2) begin
                chk_i("t6_pkt_cnt_after_t3", int'(pkt_cnt), 2);
                chk_i("t6_err_cnt_after_t3", int'(err_cnt), 1);
            end
`endif
        end

        // Backpressure: four words fill the FIFO, third packet must stall until release
        t2_base[0] = 8'h00;
        t2_base[1] = 8'h55;
        t2_base[2] = 8'hAA;
        bus_ready = 1'b0;
        wb = got_n;
        eb = err_total;
        send_pkt(128, 1'b1, 1'b1, -1, t2_base[0]);
        send_pkt(128, 1'b1, 1'b1, -1, t2_base[1]);
        @(negedge clk);
        chk_i("t2_ready_low", int'(st_ready), 0);
        chk_i("t2_valid_held", int'(bus_valid), 1);
        chk_i("t2_head_sop", int'(bus_sop), 1);
        chk_w("t2_head_data", bus_data, exp_word(t2_base[0], 0, 64));
        fork
            send_pkt(128, 1'b1, 1'b1, -1, t2_base[2]);
            begin
                repeat (6) @(negedge clk);
                chk_i("t2_ready_stall", int'(st_ready), 0);
                chk_i("t2_no_early_words", got_n - wb, 0);
                @(posedge clk);
                #1;
                bus_ready = 1'b1;
            end
        join
        repeat (20) @(posedge clk);
        #1;
        chk_i("t2_words", got_n - wb, 6);
        for (int p = 0; p < 3; p++)
            check_words($sformatf("t2_p%0d", p), wb + 2 * p, 2, t2_base[p], 0, 128);
        chk_i("t2_pkt_err", err_total - eb, 0);

        // Asynchronous reset in the middle of a packet with a word waiting in the FIFO
        bus_ready = 1'b0;
        eb = err_total;
        send_pkt(70, 1'b1, 1'b0, -1, 8'h20);
        #1;
        chk_i("t5_valid_before_rst", int'(bus_valid), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_i("t5_valid_in_rst", int'(bus_valid), 0);
        chk_w("t5_data_in_rst", bus_data, '0);
        chk_i("t5_ready_in_rst", int'(st_ready), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus_ready = 1'b1;
        wb = got_n;
        send_pkt(128, 1'b1, 1'b1, -1, 8'h33);
        repeat (10) @(posedge clk);
        #1;
        chk_i("t5_words", got_n - wb, 2);
        check_words("t5", wb, 2, 8'h33, 0, 128);
        chk_i("t5_pkt_err", err_total - eb, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
